traffic_light_monitor: RTL

//   Passive checker on the far end of the traffic-light interface.
//   - Samples the Red/Green/Yellow lamp lines driven by the light controller.
//   - Decodes the current phase and measures how many cycles each phase lasts.
//   - Checks phase order and duration limits; latches sticky error flags.
//   - Counts completed light cycles. Sits beside the controller at top level
//     (or in the bench) and never drives the lamps.

---
 rtl/traffic_light_monitor.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/traffic_light_monitor.sv
// traffic_light_monitor
//   Passive checker for a Red/Green/Yellow lamp interface. It decodes the
//   current phase from the lamp lines, measures how long each phase lasts,
//   checks phase order and duration limits, and counts completed light cycles.
//   It never drives the lamps.
//
// Ports
//   clk          in   rising-edge clock
//   reset        in   synchronous, active-high; discards all history
//   Red/Green/Yellow in lamp lines, synchronous to clk
//   clear        in   synchronous clear of the sticky error flags
//   phase        out  00 none/unsynced, 01 red, 10 green, 11 yellow
//   last_dur     out  duration of the most recently completed phase
//   dur_valid    out  one-cycle pulse when last_dur updates
//   cycle_count  out  completed legal Yellow->Red transitions (wraps)
//   err_onehot   out  sticky: lamp code not exactly one-hot
//   err_seq      out  sticky: illegal phase transition
//   err_time     out  sticky: phase duration outside its legal window
//   err_any      out  OR of the sticky flags (combinational)
module traffic_light_monitor #(
  parameter int CNT_W = 8,
  parameter int CYC_W = 16,
  parameter int R_MIN = 4,
  parameter int R_MAX = 16,
  parameter int G_MIN = 4,
  parameter int G_MAX = 16,
  parameter int Y_MIN = 1,
  parameter int Y_MAX = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Red,
  input  logic             Green,
  input  logic             Yellow,
  input  logic             clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] last_dur,
  output logic             dur_valid,
  output logic [CYC_W-1:0] cycle_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic             err_time,
  output logic             err_any
);

  typedef enum logic [1:0] {
    PH_NONE = 2'b00,
    PH_RED  = 2'b01,
    PH_GRN  = 2'b10,
    PH_YEL  = 2'b11
  } phase_e;

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] dur_q, dur_d;
  logic [CNT_W-1:0] last_dur_q, last_dur_d;
  logic             dur_valid_q, dur_valid_d;
  logic [CYC_W-1:0] cycle_count_q, cycle_count_d;
  logic             first_q, first_d;
  logic             err_onehot_q, err_onehot_d;
  logic             err_seq_q, err_seq_d;
  logic             err_time_q, err_time_d;

  logic             code_ok;
  phase_e           code_ph;
  logic             set_onehot, set_seq, set_time;

  function automatic logic [CNT_W-1:0] ph_min(input phase_e p);
    case (p)
      PH_RED:  return CNT_W'(R_MIN);
      PH_GRN:  return CNT_W'(G_MIN);
      PH_YEL:  return CNT_W'(Y_MIN);
      default: return '0;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] ph_max(input phase_e p);
    case (p)
      PH_RED:  return CNT_W'(R_MAX);
      PH_GRN:  return CNT_W'(G_MAX);
      PH_YEL:  return CNT_W'(Y_MAX);
      default: return '1;
    endcase
  endfunction

  // Only successor reachable without an order error.
  function automatic phase_e legal_next(input phase_e p);
    case (p)
      PH_RED:  return PH_GRN;
      PH_GRN:  return PH_YEL;
      default: return PH_RED;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] d);
    return (d == '1) ? d : d + CNT_W'(1);
  endfunction

  assign code_ok = $onehot({Red, Green, Yellow});
  assign code_ph = Red ? PH_RED : (Green ? PH_GRN : PH_YEL);

  always_comb begin
    phase_d       = phase_q;
    dur_d         = dur_q;
    last_dur_d    = last_dur_q;
    dur_valid_d   = 1'b0;
    cycle_count_d = cycle_count_q;
    first_d       = first_q;
    set_onehot    = 1'b0;
    set_seq       = 1'b0;
    set_time      = 1'b0;

    if (!code_ok) begin
      set_onehot = 1'b1;
      phase_d    = PH_NONE;
      dur_d      = '0;
      first_d    = 1'b1;
    end else if (code_ph == phase_q) begin
      // Flag an overrun as soon as the phase outlives its maximum, rather
      // than waiting for it to end.
      if (!first_q && (dur_q == ph_max(phase_q)))
        set_time = 1'b1;
      dur_d = sat_inc(dur_q);
    end else if (phase_q == PH_NONE) begin
      phase_d = code_ph;
      dur_d   = CNT_W'(1);
    end else begin
      last_dur_d  = dur_q;
      dur_valid_d = 1'b1;
      if (code_ph != legal_next(phase_q))
        set_seq = 1'b1;
      // The phase seen right after sync may be partial, so it is not timed.
      if (!first_q && ((dur_q < ph_min(phase_q)) || (dur_q > ph_max(phase_q))))
        set_time = 1'b1;
      if ((phase_q == PH_YEL) && (code_ph == PH_RED))
        cycle_count_d = cycle_count_q + CYC_W'(1);
      phase_d = code_ph;
      dur_d   = CNT_W'(1);
      first_d = 1'b0;
    end

    // New events win over a coincident clear.
    err_onehot_d = (err_onehot_q & ~clear) | set_onehot;
    err_seq_d    = (err_seq_q    & ~clear) | set_seq;
    err_time_d   = (err_time_q   & ~clear) | set_time;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q       <= PH_NONE;
      dur_q         <= '0;
      last_dur_q    <= '0;
      dur_valid_q   <= 1'b0;
      cycle_count_q <= '0;
      first_q       <= 1'b1;
      err_onehot_q  <= 1'b0;
      err_seq_q     <= 1'b0;
      err_time_q    <= 1'b0;
    end else begin
      phase_q       <= phase_d;
      dur_q         <= dur_d;
      last_dur_q    <= last_dur_d;
      dur_valid_q   <= dur_valid_d;
      cycle_count_q <= cycle_count_d;
      first_q       <= first_d;
      err_onehot_q  <= err_onehot_d;
      err_seq_q     <= err_seq_d;
      err_time_q    <= err_time_d;
    end
  end

  assign phase       = phase_q;
  assign last_dur    = last_dur_q;
  assign dur_valid   = dur_valid_q;
  assign cycle_count = cycle_count_q;
  assign err_onehot  = err_onehot_q;
  assign err_seq     = err_seq_q;
  assign err_time    = err_time_q;
  assign err_any     = err_onehot_q | err_seq_q | err_time_q;

endmodule
